// File: rtl/alu_pkg.sv
// Shared widths, opcode encodings and requester-id type for the ALU arbiter slice.
package alu_pkg;

  localparam int DW  = 4;
  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_NOT = 3'b000;
  localparam logic [OPW-1:0] OP_AND = 3'b001;
  localparam logic [OPW-1:0] OP_OR  = 3'b010;
  localparam logic [OPW-1:0] OP_XOR = 3'b011;
  localparam logic [OPW-1:0] OP_ADD = 3'b100;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/my_ALU.sv
// Purpose: 4-bit logic/add ALU; unused opcodes yield zero result and carry.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module my_ALU
  import alu_pkg::*;
(
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [OPW-1:0] op,
  output logic [DW-1:0]  c,
  output logic           co
);

  always_comb begin
    c  = '0;
    co = 1'b0;
    case (op)
      OP_NOT:  c = ~a;
      OP_AND:  c = a & b;
      OP_OR:   c = a | b;
      OP_XOR:  c = a ^ b;
      OP_ADD:  {co, c} = {1'b0, a} + {1'b0, b};
      default: begin
        c  = '0;
        co = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Purpose: round-robin share of one my_ALU between two requesters, tagged result register.
// Latency: result visible on rsp_* right after the accepting edge.
// Backpressure: full result register with rsp_ready low drops both readies; drain+accept in one cycle.
module alu_rr_arbiter
  import alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,

  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,

  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,

  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [DW-1:0]  rsp_c,
  output logic           rsp_co,
  output logic           rsp_id
);

  req_id_t        last_id;
  req_id_t        gnt_id;
  logic           gnt_vld;
  logic           slot_free;
  logic           accept;

  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_c;
  logic           alu_co;

  assign slot_free = !rsp_valid || rsp_ready;
  assign gnt_vld   = req0_valid || req1_valid;

  // Under contention the requester not served last wins; otherwise the lone valid one.
  always_comb begin
    gnt_id = REQ0;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_id;
    end else if (req1_valid) begin
      gnt_id = REQ1;
    end
  end

  assign req0_ready = slot_free && gnt_vld && (gnt_id == REQ0);
  assign req1_ready = slot_free && gnt_vld && (gnt_id == REQ1);
  assign accept     = slot_free && gnt_vld;

  assign alu_a  = (gnt_id == REQ1) ? req1_a  : req0_a;
  assign alu_b  = (gnt_id == REQ1) ? req1_b  : req0_b;
  assign alu_op = (gnt_id == REQ1) ? req1_op : req0_op;

  my_ALU u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .c  (alu_c),
    .co (alu_co)
  );

  // rsp_valid is the EMPTY/FULL state; data registers only move on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      rsp_co    <= 1'b0;
      rsp_id    <= REQ0;
      last_id   <= REQ1;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_c     <= alu_c;
      rsp_co    <= alu_co;
      rsp_id    <= gnt_id;
      last_id   <= gnt_id;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: reset, single op, contention, backpressure, opcodes, async reset.
module tb_alu_rr_arbiter;
  import alu_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req0_ready;
  logic [DW-1:0]  req0_a, req0_b;
  logic [OPW-1:0] req0_op;
  logic           req1_valid, req1_ready;
  logic [DW-1:0]  req1_a, req1_b;
  logic [OPW-1:0] req1_op;
  logic           rsp_valid, rsp_ready;
  logic [DW-1:0]  rsp_c;
  logic           rsp_co, rsp_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_c      (rsp_c),
    .rsp_co     (rsp_co),
    .rsp_id     (rsp_id)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [DW-1:0] c,
                         input logic co, input logic id);
    chk({tag, ".valid"}, {7'd0, rsp_valid}, {7'd0, v});
    chk({tag, ".c"},     {4'd0, rsp_c},     {4'd0, c});
    chk({tag, ".co"},    {7'd0, rsp_co},    {7'd0, co});
    chk({tag, ".id"},    {7'd0, rsp_id},    {7'd0, id});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".rdy0"}, {7'd0, req0_ready}, {7'd0, r0});
    chk({tag, ".rdy1"}, {7'd0, req1_ready}, {7'd0, r1});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    set0(1'b0, OP_NOT, 4'h0, 4'h0);
    set1(1'b0, OP_NOT, 4'h0, 4'h0);

    // Reset held for two cycles
    step();
    step();
    chk_rsp("reset", 1'b0, 4'h0, 1'b0, 1'b0);
    chk_rdy("reset", 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk_rdy("idle", 1'b0, 1'b0);

    // Single ADD with carry
    step();
    set0(1'b1, OP_ADD, 4'b1110, 4'b0100);
    rsp_ready = 1'b1;
    #1;
    chk_rdy("single", 1'b1, 1'b0);
    step();
    set0(1'b0, OP_NOT, 4'h0, 4'h0);
    chk_rsp("single", 1'b1, 4'b0010, 1'b1, 1'b0);
    step();
    chk("drain.valid", {7'd0, rsp_valid}, 8'd0);

    // Contention right after reset: req0 first
    pulse_reset();
    set0(1'b1, OP_AND, 4'b1111, 4'b1000);
    set1(1'b1, OP_XOR, 4'b1110, 4'b1000);
    rsp_ready = 1'b1;
    #1;
    chk_rdy("cont", 1'b1, 1'b0);
    step();
    set0(1'b0, OP_NOT, 4'h0, 4'h0);
    chk_rsp("cont0", 1'b1, 4'b1000, 1'b0, 1'b0);
    #1;
    chk_rdy("cont1", 1'b0, 1'b1);
    step();
    set1(1'b0, OP_NOT, 4'h0, 4'h0);
    chk_rsp("cont1", 1'b1, 4'b0110, 1'b0, 1'b1);

    // Backpressure: three stalled cycles, then drain+accept together
    rsp_ready = 1'b0;
    set1(1'b1, OP_OR, 4'b0011, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_rdy("stall", 1'b0, 1'b0);
      step();
      chk_rsp("stall", 1'b1, 4'b0110, 1'b0, 1'b1);
    end
    rsp_ready = 1'b1;
    #1;
    chk_rdy("release", 1'b0, 1'b1);
    step();
    set1(1'b0, OP_NOT, 4'h0, 4'h0);
    chk_rsp("release", 1'b1, 4'b0111, 1'b0, 1'b1);

    // Continuous contention alternates 0,1,0 (last served was 1)
    set0(1'b1, OP_NOT, 4'b0101, 4'b0000);
    set1(1'b1, OP_ADD, 4'b1000, 4'b1001);
    step();
    chk_rsp("rr0", 1'b1, 4'b1010, 1'b0, 1'b0);
    step();
    chk_rsp("rr1", 1'b1, 4'b0001, 1'b1, 1'b1);
    step();
    chk_rsp("rr2", 1'b1, 4'b1010, 1'b0, 1'b0);
    set0(1'b0, OP_NOT, 4'h0, 4'h0);
    set1(1'b0, OP_NOT, 4'h0, 4'h0);

    // Unused opcode from requester 1
    set1(1'b1, 3'b111, 4'b1001, 4'b0001);
    step();
    set1(1'b0, OP_NOT, 4'h0, 4'h0);
    chk_rsp("unused", 1'b1, 4'b0000, 1'b0, 1'b1);

    // Stall fairness: contention during a stall, last_id=1 keeps req0 first on release
    rsp_ready = 1'b0;
    set0(1'b1, OP_OR, 4'b1000, 4'b0001);
    set1(1'b1, OP_AND, 4'b1100, 4'b0100);
    step();
    step();
    chk_rsp("sfair.hold", 1'b1, 4'b0000, 1'b0, 1'b1);
    rsp_ready = 1'b1;
    step();
    set0(1'b0, OP_NOT, 4'h0, 4'h0);
    set1(1'b0, OP_NOT, 4'h0, 4'h0);
    chk_rsp("sfair", 1'b1, 4'b1001, 1'b0, 1'b0);

    // Asynchronous reset while FULL and stalled
    rsp_ready = 1'b0;
    step();
    chk("premid.valid", {7'd0, rsp_valid}, 8'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_rsp("midreset", 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    #1;
    chk("postrst.valid", {7'd0, rsp_valid}, 8'd0);
    set0(1'b1, OP_XOR, 4'b1010, 4'b0110);
    set1(1'b1, OP_OR,  4'b0001, 4'b0010);
    rsp_ready = 1'b1;
    #1;
    chk_rdy("postrst", 1'b1, 1'b0);
    step();
    set0(1'b0, OP_NOT, 4'h0, 4'h0);
    chk_rsp("postrst", 1'b1, 4'b1100, 1'b0, 1'b0);
    step();
    set1(1'b0, OP_NOT, 4'h0, 4'h0);
    chk_rsp("postrst1", 1'b1, 4'b0011, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
